// File: rtl/auth_session_if.sv
// Signal bundle between the ATM session controller and its environment:
// card reader, keypad, combinational Authenticator and transaction stages.
interface auth_session_if;
    logic        card_inserted;
    logic [3:0]  acc_num_in;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        key_enter;
    logic        key_cancel;
    logic        acc_found_stat;
    logic        acc_auth_stat;
    logic [3:0]  acc_index_in;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [2:0]  digit_cnt;
    logic [2:0]  attempts_left;
    logic        session_auth;
    logic [3:0]  acc_index;
    logic        locked;
    logic        err_short_pin;
    logic        err_no_account;
    logic        err_timeout;

    modport master (
        output card_inserted, acc_num_in, key_valid, key_digit, key_enter, key_cancel,
        output acc_found_stat, acc_auth_stat, acc_index_in,
        input  acc_num, pin, digit_cnt, attempts_left, session_auth, acc_index,
        input  locked, err_short_pin, err_no_account, err_timeout
    );

    modport slave (
        input  card_inserted, acc_num_in, key_valid, key_digit, key_enter, key_cancel,
        input  acc_found_stat, acc_auth_stat, acc_index_in,
        output acc_num, pin, digit_cnt, attempts_left, session_auth, acc_index,
        output locked, err_short_pin, err_no_account, err_timeout
    );
endinterface

// File: rtl/auth_session_ctrl.sv
// ATM session front-end: PIN collection, retry lockout and keypad timeout.
// Optional macro LOCK_PERSIST_EN keeps per-account lockout until reset.
module auth_session_ctrl #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic           clk,
    input logic           rst_n,
    auth_session_if.slave bus
);
    localparam int         TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ENTER_PIN = 3'd1;
    localparam logic [2:0] ST_CHECK     = 3'd2;
    localparam logic [2:0] ST_AUTH_OK   = 3'd3;
    localparam logic [2:0] ST_LOCKED    = 3'd4;

    logic [2:0]    state;
    logic          card_q;
    logic [TW-1:0] timer;
    logic [3:0]    acc_num_r;
    logic [15:0]   pin_r;
    logic [2:0]    digit_cnt_r;
    logic [2:0]    attempts_r;
    logic          session_auth_r;
    logic [3:0]    acc_index_r;
    logic          locked_r;
    logic          err_short_r;
    logic          err_no_acc_r;
    logic          err_timeout_r;

    logic       abort;
    logic       digit_ok;
    logic [2:0] attempts_dec;

    assign abort        = (state != ST_IDLE) &&
                          (!bus.card_inserted || (bus.key_cancel && state != ST_LOCKED));
    assign digit_ok     = (bus.key_digit <= 4'd9) && (digit_cnt_r < 3'd4);
    assign attempts_dec = attempts_r - 3'd1;

`ifdef LOCK_PERSIST_EN
    logic [15:0] lock_vec;

    // NOTE: this is a small flag array, so it is cleared by reset like any register;
    // clearing on reset is also the only way a persisted lockout is released.
    always_ff @(posedge clk) begin
        if (!rst_n)
            lock_vec <= '0;
        else if (state == ST_LOCKED)
            lock_vec[acc_num_r] <= 1'b1;
    end
`endif

    // NOTE: all state is updated with non-blocking assignments so every branch
    // below sees the pre-edge values of state, timer and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            card_q         <= 1'b0;
            timer          <= '0;
            acc_num_r      <= '0;
            pin_r          <= '0;
            digit_cnt_r    <= '0;
            attempts_r     <= '0;
            session_auth_r <= 1'b0;
            acc_index_r    <= '0;
            locked_r       <= 1'b0;
            err_short_r    <= 1'b0;
            err_no_acc_r   <= 1'b0;
            err_timeout_r  <= 1'b0;
        end else begin
            card_q        <= bus.card_inserted;
            err_short_r   <= 1'b0;
            err_no_acc_r  <= 1'b0;
            err_timeout_r <= 1'b0;

            if (abort) begin
                state          <= ST_IDLE;
                pin_r          <= '0;
                digit_cnt_r    <= '0;
                session_auth_r <= 1'b0;
                locked_r       <= 1'b0;
            end else begin
                case (state)
                    // A session starts only on a fresh insertion, so an aborted
                    // card must be pulled and reinserted.
                    ST_IDLE: begin
                        if (bus.card_inserted && !card_q) begin
                            acc_num_r   <= bus.acc_num_in;
                            pin_r       <= '0;
                            digit_cnt_r <= '0;
                            timer       <= '0;
`ifdef LOCK_PERSIST_EN
                            if (lock_vec[bus.acc_num_in]) begin
                                state      <= ST_LOCKED;
                                locked_r   <= 1'b1;
                                attempts_r <= '0;
                            end else begin
                                state      <= ST_ENTER_PIN;
                                attempts_r <= 3'(MAX_ATTEMPTS);
                            end
`else
                            state      <= ST_ENTER_PIN;
                            attempts_r <= 3'(MAX_ATTEMPTS);
`endif
                        end
                    end

                    ST_ENTER_PIN: begin
                        if (bus.key_enter) begin
                            timer <= '0;
                            if (digit_cnt_r == 3'd4) begin
                                state <= ST_CHECK;
                            end else begin
                                err_short_r <= 1'b1;
                                pin_r       <= '0;
                                digit_cnt_r <= '0;
                            end
                        end else if (bus.key_valid) begin
                            timer <= '0;
                            if (digit_ok) begin
                                pin_r       <= {pin_r[11:0], bus.key_digit};
                                digit_cnt_r <= digit_cnt_r + 3'd1;
                            end
                        end else if (timer == TIMER_LAST) begin
                            state         <= ST_IDLE;
                            err_timeout_r <= 1'b1;
                            pin_r         <= '0;
                            digit_cnt_r   <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end

                    ST_CHECK: begin
                        if (!bus.acc_found_stat) begin
                            state        <= ST_IDLE;
                            err_no_acc_r <= 1'b1;
                            pin_r        <= '0;
                            digit_cnt_r  <= '0;
                        end else if (bus.acc_auth_stat) begin
                            state          <= ST_AUTH_OK;
                            acc_index_r    <= bus.acc_index_in;
                            session_auth_r <= 1'b1;
                        end else begin
                            attempts_r <= attempts_dec;
                            if (attempts_dec == 3'd0) begin
                                state    <= ST_LOCKED;
                                locked_r <= 1'b1;
                            end else begin
                                state       <= ST_ENTER_PIN;
                                pin_r       <= '0;
                                digit_cnt_r <= '0;
                                timer       <= '0;
                            end
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    assign bus.acc_num        = acc_num_r;
    assign bus.pin            = pin_r;
    assign bus.digit_cnt      = digit_cnt_r;
    assign bus.attempts_left  = attempts_r;
    assign bus.session_auth   = session_auth_r;
    assign bus.acc_index      = acc_index_r;
    assign bus.locked         = locked_r;
    assign bus.err_short_pin  = err_short_r;
    assign bus.err_no_account = err_no_acc_r;
    assign bus.err_timeout    = err_timeout_r;
endmodule

// File: tb/tb_auth_session_ctrl.sv
// Bench for auth_session_ctrl: scripted vector table, corner-case sequences and
// randomized traffic against a queue-based session model.
module tb_auth_session_ctrl;
    localparam int MAX_ATTEMPTS   = 3;
    localparam int TIMEOUT_CYCLES = 8;
`ifdef LOCK_PERSIST_EN
    localparam bit PERSIST = 1'b1;
`else
    localparam bit PERSIST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    auth_session_if bus();

    auth_session_ctrl #(
        .MAX_ATTEMPTS  (MAX_ATTEMPTS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Authenticator database: acc 3 -> PIN 1234 at index 2, acc 5 -> PIN 0000 at index 7.
    typedef struct packed {
        logic       found;
        logic       auth;
        logic [3:0] idx;
    } resp_t;

    function automatic resp_t lookup(input logic [3:0] acc, input logic [15:0] p);
        resp_t r;
        r = '0;
        if (acc == 4'd3) begin
            r.found = 1'b1;
            r.auth  = (p == 16'h1234);
            r.idx   = 4'd2;
        end else if (acc == 4'd5) begin
            r.found = 1'b1;
            r.auth  = (p == 16'h0000);
            r.idx   = 4'd7;
        end
        return r;
    endfunction

    resp_t resp;
    assign resp               = lookup(bus.acc_num, bus.pin);
    assign bus.acc_found_stat = resp.found;
    assign bus.acc_auth_stat  = resp.auth;
    assign bus.acc_index_in   = resp.idx;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_ENTRY, M_VERIFY, M_SESSION, M_LOCKOUT} mode_t;
    mode_t m_mode;
    int    m_digits[$];
    int    m_acc, m_attempts, m_idle, m_index;
    bit    m_card_prev, m_short, m_noacc, m_tout;
    bit    m_lockset[16];

    function automatic int pin_value();
        int p = 0;
        foreach (m_digits[i]) p = p * 16 + m_digits[i];
        return p;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_digits.delete();
        m_acc = 0; m_attempts = 0; m_idle = 0; m_index = 0;
        m_card_prev = 0; m_short = 0; m_noacc = 0; m_tout = 0;
        foreach (m_lockset[i]) m_lockset[i] = 0;
    endtask

    task automatic leave();
        m_mode = M_IDLE;
        m_digits.delete();
    endtask

    task automatic model_step();
        bit    prev;
        resp_t r;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_short = 0; m_noacc = 0; m_tout = 0;
        prev = m_card_prev;
        m_card_prev = bus.card_inserted;
        if (m_mode != M_IDLE && (!bus.card_inserted || (bus.key_cancel && m_mode != M_LOCKOUT))) begin
            leave();
            return;
        end
        case (m_mode)
            M_IDLE: if (bus.card_inserted && !prev) begin
                m_acc = int'(bus.acc_num_in);
                m_digits.delete();
                m_idle = 0;
                if (PERSIST && m_lockset[m_acc]) begin
                    m_mode = M_LOCKOUT; m_attempts = 0;
                end else begin
                    m_mode = M_ENTRY; m_attempts = MAX_ATTEMPTS;
                end
            end
            M_ENTRY: if (bus.key_enter) begin
                m_idle = 0;
                if (m_digits.size() == 4) m_mode = M_VERIFY;
                else begin m_short = 1; m_digits.delete(); end
            end else if (bus.key_valid) begin
                m_idle = 0;
                if (int'(bus.key_digit) <= 9 && m_digits.size() < 4) m_digits.push_back(int'(bus.key_digit));
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT_CYCLES) begin m_tout = 1; leave(); end
            end
            M_VERIFY: begin
                r = lookup(4'(m_acc), 16'(pin_value()));
                if (!r.found) begin
                    m_noacc = 1; leave();
                end else if (r.auth) begin
                    m_mode = M_SESSION; m_index = int'(r.idx);
                end else begin
                    m_attempts--;
                    if (m_attempts == 0) begin
                        m_mode = M_LOCKOUT; m_lockset[m_acc] = 1;
                    end else begin
                        m_mode = M_ENTRY; m_digits.delete(); m_idle = 0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input int card, input int acc, input int kv, input int kd, input int ke, input int kc);
        bus.card_inserted = (card != 0);
        bus.acc_num_in    = 4'(acc);
        bus.key_valid     = (kv != 0);
        bus.key_digit     = 4'(kd);
        bus.key_enter     = (ke != 0);
        bus.key_cancel    = (kc != 0);
    endtask

    function automatic logic [31:0] errs();
        return 32'({bus.err_short_pin, bus.err_no_account, bus.err_timeout});
    endfunction

    task automatic wrong_try_acc3();
        int ds[4] = '{1, 2, 3, 5};
        foreach (ds[i]) begin drive(1, 3, 1, ds[i], 0, 0); tick(); end
        drive(1, 3, 0, 0, 1, 0); tick();
        drive(1, 3, 0, 0, 0, 0); tick();
    endtask

    task automatic check_model();
        check("rand acc_num",       32'(bus.acc_num),       32'(m_acc));
        check("rand pin",           32'(bus.pin),           32'(pin_value()));
        check("rand digit_cnt",     32'(bus.digit_cnt),     32'(m_digits.size()));
        check("rand attempts_left", 32'(bus.attempts_left), 32'(m_attempts));
        check("rand session_auth",  32'(bus.session_auth),  32'(m_mode == M_SESSION));
        check("rand acc_index",     32'(bus.acc_index),     32'(m_index));
        check("rand locked",        32'(bus.locked),        32'(m_mode == M_LOCKOUT));
        check("rand errs",          errs(),                 32'({m_short, m_noacc, m_tout}));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int card, acc, kv, kd, ke, kc;
        int cnt, pin, att, auth, idx, lock, err;   // err = {short, no_account, timeout}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input int card, input int acc, input int kv, input int kd, input int ke,
                               input int kc, input int cnt, input int pin, input int att, input int auth,
                               input int idx, input int lock, input int err);
        vec_t r;
        r.card = card; r.acc = acc; r.kv = kv; r.kd = kd; r.ke = ke; r.kc = kc;
        r.cnt = cnt; r.pin = pin; r.att = att; r.auth = auth; r.idx = idx; r.lock = lock; r.err = err;
        return r;
    endfunction

    initial begin
        int ds[4] = '{1, 2, 3, 5};
        int ps[4] = '{'h0001, 'h0012, 'h0123, 'h1235};

        // Good PIN path with short-PIN, invalid-digit and fifth-digit corners.
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0, 'h0000, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 0,  0, 0, 0, 0, 'h0000, 3, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 1,  1, 0, 0, 1, 'h0001, 3, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 1,  2, 0, 0, 2, 'h0012, 3, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 1, 12, 0, 0, 2, 'h0012, 3, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 0,  0, 1, 0, 0, 'h0000, 3, 0, 0, 0, 4));
        vecs.push_back(v(1, 3, 1,  1, 0, 0, 1, 'h0001, 3, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 1,  2, 0, 0, 2, 'h0012, 3, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 1,  3, 0, 0, 3, 'h0123, 3, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 1,  4, 0, 0, 4, 'h1234, 3, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 1,  5, 0, 0, 4, 'h1234, 3, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 1,  7, 1, 0, 4, 'h1234, 3, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 0,  0, 0, 0, 4, 'h1234, 3, 1, 2, 0, 0));
        vecs.push_back(v(1, 3, 1,  9, 0, 0, 4, 'h1234, 3, 1, 2, 0, 0));
        vecs.push_back(v(0, 3, 0,  0, 0, 0, 0, 'h0000, 3, 0, 2, 0, 0));
        vecs.push_back(v(1, 3, 0,  0, 0, 0, 0, 'h0000, 3, 0, 2, 0, 0));
        // Three wrong tries lock the session.
        for (int t = 0; t < 3; t++) begin
            foreach (ds[i]) vecs.push_back(v(1, 3, 1, ds[i], 0, 0, i + 1, ps[i], 3 - t, 0, 2, 0, 0));
            vecs.push_back(v(1, 3, 0, 0, 1, 0, 4, 'h1235, 3 - t, 0, 2, 0, 0));
            if (t < 2) vecs.push_back(v(1, 3, 0, 0, 0, 0, 0, 'h0000, 2 - t, 0, 2, 0, 0));
            else       vecs.push_back(v(1, 3, 0, 0, 0, 0, 4, 'h1235, 0, 0, 2, 1, 0));
        end
        vecs.push_back(v(1, 3, 0,  0, 0, 1, 4, 'h1235, 0, 0, 2, 1, 0));
        vecs.push_back(v(1, 3, 1,  1, 1, 0, 4, 'h1235, 0, 0, 2, 1, 0));
        vecs.push_back(v(0, 3, 0,  0, 0, 0, 0, 'h0000, 0, 0, 2, 0, 0));
        // Unknown account, no re-entry without reinsertion, cancel mid-entry.
        vecs.push_back(v(1, 9, 0,  0, 0, 0, 0, 'h0000, 3, 0, 2, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(v(1, 9, 1, 0, 0, 0, i + 1, 'h0000, 3, 0, 2, 0, 0));
        vecs.push_back(v(1, 9, 0,  0, 1, 0, 4, 'h0000, 3, 0, 2, 0, 0));
        vecs.push_back(v(1, 9, 0,  0, 0, 0, 0, 'h0000, 3, 0, 2, 0, 2));
        vecs.push_back(v(1, 9, 1,  1, 0, 0, 0, 'h0000, 3, 0, 2, 0, 0));
        vecs.push_back(v(0, 9, 0,  0, 0, 0, 0, 'h0000, 3, 0, 2, 0, 0));
        vecs.push_back(v(1, 5, 0,  0, 0, 0, 0, 'h0000, 3, 0, 2, 0, 0));
        vecs.push_back(v(1, 5, 1,  8, 0, 0, 1, 'h0008, 3, 0, 2, 0, 0));
        vecs.push_back(v(1, 5, 0,  0, 0, 1, 0, 'h0000, 3, 0, 2, 0, 0));
        vecs.push_back(v(0, 5, 0,  0, 0, 1, 0, 'h0000, 3, 0, 2, 0, 0));

        // Reset state.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();
        check("reset acc_num",       32'(bus.acc_num), 0);
        check("reset pin",           32'(bus.pin), 0);
        check("reset digit_cnt",     32'(bus.digit_cnt), 0);
        check("reset attempts_left", 32'(bus.attempts_left), 0);
        check("reset session_auth",  32'(bus.session_auth), 0);
        check("reset acc_index",     32'(bus.acc_index), 0);
        check("reset locked",        32'(bus.locked), 0);
        check("reset errs",          errs(), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].card, vecs[i].acc, vecs[i].kv, vecs[i].kd, vecs[i].ke, vecs[i].kc);
            tick();
            check($sformatf("row%0d digit_cnt", i),     32'(bus.digit_cnt),     vecs[i].cnt);
            check($sformatf("row%0d pin", i),           32'(bus.pin),           vecs[i].pin);
            check($sformatf("row%0d attempts_left", i), 32'(bus.attempts_left), vecs[i].att);
            check($sformatf("row%0d session_auth", i),  32'(bus.session_auth),  vecs[i].auth);
            check($sformatf("row%0d acc_index", i),     32'(bus.acc_index),     vecs[i].idx);
            check($sformatf("row%0d locked", i),        32'(bus.locked),        vecs[i].lock);
            check($sformatf("row%0d errs", i),          errs(),                 vecs[i].err);
        end

        // Timeout: a key restarts the count; the 8th idle cycle aborts.
        drive(1, 5, 0, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) tick();
        drive(1, 5, 1, 9, 0, 0); tick();
        check("to key pin", 32'(bus.pin), 'h0009);
        drive(1, 5, 0, 0, 0, 0);
        for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
            tick();
            check($sformatf("to idle%0d err_timeout", k), 32'(bus.err_timeout), 32'(k == TIMEOUT_CYCLES));
        end
        check("to digit_cnt", 32'(bus.digit_cnt), 0);
        drive(1, 5, 1, 1, 0, 0); tick();
        check("to no reentry cnt", 32'(bus.digit_cnt), 0);
        check("to pulse width",    32'(bus.err_timeout), 0);

        // Reset in the middle of PIN entry.
        drive(0, 5, 0, 0, 0, 0); tick();
        drive(1, 5, 0, 0, 0, 0); tick();
        drive(1, 5, 1, 7, 0, 0); tick();
        check("mid digit_cnt", 32'(bus.digit_cnt), 1);
        rst_n = 1'b0;
        drive(1, 5, 0, 0, 0, 0); tick();
        check("mid rst acc_num",   32'(bus.acc_num), 0);
        check("mid rst pin",       32'(bus.pin), 0);
        check("mid rst attempts",  32'(bus.attempts_left), 0);
        check("mid rst errs",      errs(), 0);
        rst_n = 1'b1;
        tick();
        check("mid post acc_num",  32'(bus.acc_num), 5);
        check("mid post attempts", 32'(bus.attempts_left), 3);

        // Lockout lifetime across card removal.
        drive(0, 3, 0, 0, 0, 0); tick();
        drive(1, 3, 0, 0, 0, 0); tick();
        for (int t = 0; t < 3; t++) wrong_try_acc3();
        check("lk locked",   32'(bus.locked), 1);
        check("lk attempts", 32'(bus.attempts_left), 0);
        drive(0, 3, 0, 0, 0, 0); tick();
        check("lk removed locked", 32'(bus.locked), 0);
        drive(1, 3, 0, 0, 0, 0); tick();
        check("lk reinsert locked",   32'(bus.locked),        PERSIST ? 1 : 0);
        check("lk reinsert attempts", 32'(bus.attempts_left), PERSIST ? 0 : 3);
        drive(0, 3, 0, 0, 0, 0); tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();
        drive(1, 3, 0, 0, 0, 0); tick();
        check("lk post-reset locked",   32'(bus.locked), 0);
        check("lk post-reset attempts", 32'(bus.attempts_left), 3);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(499, 0) != 0);
            if ($urandom_range(39, 0) == 0) bus.card_inserted = ~bus.card_inserted;
            if (!bus.card_inserted) begin
                case ($urandom_range(3, 0))
                    0:       bus.acc_num_in = 4'd3;
                    1:       bus.acc_num_in = 4'd5;
                    2:       bus.acc_num_in = 4'd9;
                    default: bus.acc_num_in = 4'($urandom_range(15, 0));
                endcase
            end
            bus.key_valid = ($urandom_range(99, 0) < 45);
            if ($urandom_range(3, 0) == 0) bus.key_digit = 4'($urandom_range(15, 0));
            else if (m_acc == 5)           bus.key_digit = 4'd0;
            else                           bus.key_digit = 4'(m_digits.size() + 1);
            bus.key_enter  = ($urandom_range(99, 0) < 8);
            bus.key_cancel = ($urandom_range(99, 0) < 2);
            tick();
            check_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/auth_session_ctrl.md
Name: auth_session_ctrl

Overview:
Session front-end for the ATM authentication path. Latches the card's account number, collects four BCD PIN keypresses and presents {acc_num, pin} to the combinational Authenticator. Consumes its found/authenticated status, enforces a retry limit with lockout and a keypad inactivity timeout, and exports a registered authenticated-session status and account index to the transaction stages.

Parameters:
MAX_ATTEMPTS, 3, wrong-PIN tries allowed per session (1..7).
TIMEOUT_CYCLES, 1000, idle cycles in PIN entry before abort (>=2).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  synchronous active-low reset, sampled on rising clk.
card_inserted  in  1  level, high while a card is present.
acc_num_in  in  4  account number read from card; valid while card_inserted=1.
key_valid  in  1  one-cycle strobe, key_digit is valid.
key_digit  in  4  keypad digit, BCD 0..9; codes 10..15 are ignored.
key_enter  in  1  one-cycle strobe, submit PIN.
key_cancel  in  1  one-cycle strobe, abort session.
acc_found_stat  in  1  from Authenticator, 1 = account exists.
acc_auth_stat  in  1  from Authenticator, 1 = PIN matches.
acc_index_in  in  4  from Authenticator, database index of the account.
acc_num  out  4  registered account number to Authenticator.
pin  out  16  registered packed-BCD PIN to Authenticator; first digit in [15:12].
digit_cnt  out  3  digits entered, 0..4, for the masked display.
attempts_left  out  3  remaining tries.
session_auth  out  1  high while the session is authenticated.
acc_index  out  4  latched index, valid while session_auth=1.
locked  out  1  high in LOCKED.
err_short_pin  out  1  one-cycle pulse.
err_no_account  out  1  one-cycle pulse.
err_timeout  out  1  one-cycle pulse.

Behaviour:
- Reset: state IDLE. acc_num, pin, digit_cnt, attempts_left, acc_index and the timeout counter are 0. session_auth, locked and all err pulses are 0.
- States: IDLE, ENTER_PIN, CHECK, AUTH_OK, LOCKED. All outputs are registered.
- Priority in every non-IDLE state, highest first:
  - card_inserted=0 → IDLE, clear pin and digit_cnt, drop session_auth/locked next cycle.
  - key_cancel → IDLE with the same clearing; cancel is ignored in LOCKED.
  - State-specific rules below.
- IDLE, card_inserted=1 → ENTER_PIN. Latch acc_num=acc_num_in, pin=0, digit_cnt=0, attempts_left=MAX_ATTEMPTS, timer=0.
- ENTER_PIN key handling:
  - key_valid with key_digit<=9 and digit_cnt<4: pin <= {pin[11:0], key_digit}, digit_cnt+1.
  - Digit >9, or digit_cnt==4: key ignored.
  - key_enter with digit_cnt==4 → CHECK.
  - key_enter with digit_cnt<4: pulse err_short_pin, clear pin and digit_cnt, stay in ENTER_PIN.
  - key_valid and key_enter in the same cycle: enter wins, digit dropped.
- ENTER_PIN timeout:
  - Timer clears on any key_valid/key_enter strobe, otherwise increments.
  - Timer==TIMEOUT_CYCLES-1 → IDLE with an err_timeout pulse; the card must be reinserted.
- CHECK lasts exactly 1 cycle and samples the Authenticator inputs. acc_num and pin have been stable for at least 1 cycle.
  - found=0: pulse err_no_account → IDLE.
  - found=1, auth=1 → AUTH_OK; acc_index<=acc_index_in; session_auth=1 from the next cycle.
  - found=1, auth=0: attempts_left decrements. If the new value is 0 → LOCKED, otherwise → ENTER_PIN with pin, digit_cnt and timer cleared.
- AUTH_OK: hold until card removal or cancel. Keys are ignored.
- LOCKED: locked=1 and keys are ignored; exit only on card removal.
- Latency: key_enter to session_auth=1 is 2 clocks (enter→CHECK, CHECK→AUTH_OK).
- Reset mid-session: immediate return to reset values on the next edge; no pulses.

Optional Feature:
LOCK_PERSIST_EN
- Defined:
  - Adds a 16-entry lock bit vector indexed by acc_num. Entering LOCKED sets bit[acc_num].
  - In IDLE, card insertion with the bit already set goes directly to LOCKED (attempts_left=0).
  - Bits clear only on rst_n=0.
- Undefined: lockout lasts only until card removal; no extra storage.

Test Plan:
- Bench model: acc 3 = PIN 16'h1234 at index 2. Insert card acc_num_in=3, keys 1,2,3,4, enter → pin=16'h1234 in CHECK; session_auth=1 and acc_index=2 two clocks after enter.
- Insert acc 3, keys 1,2,3,5, enter three times (reentering the PIN between tries) → attempts_left 3→2→1→0, locked=1. Remove card → IDLE, locked=0.
- Insert acc 9 (absent), keys 0,0,0,0, enter → err_no_account pulse, state IDLE.
- Keys 1,2 then enter → err_short_pin, digit_cnt=0. Key 12 → ignored. Fifth digit after 4 → ignored, pin unchanged.
- TIMEOUT_CYCLES=8: insert card and press no keys → err_timeout on the 8th idle cycle, IDLE. key_cancel mid-entry → IDLE, pin=0.
- LOCK_PERSIST_EN: lock acc 3, remove, reinsert → LOCKED directly. Assert rst_n=0 → reinsertion enters ENTER_PIN.
